alu8_seq_ctrl: RTL and testbench



---
 rtl/alu8_seq_pkg.sv | 44 ++++
 rtl/alu8_seq_dec.sv | 87 ++++++++
 rtl/alu8_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_alu8_seq_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu8_seq_pkg.sv
// Shared definitions for the 8-bit ALU sequencer: opcodes, FSM states,
// ALU output-mux encodings, flag-update mask and STATUS bit positions.
package alu8_seq_pkg;

  localparam logic [3:0] OP_MOVWF  = 4'b0000;
  localparam logic [3:0] OP_CLRF   = 4'b0001;
  localparam logic [3:0] OP_SUBWF  = 4'b0010;
  localparam logic [3:0] OP_DECF   = 4'b0011;
  localparam logic [3:0] OP_IORWF  = 4'b0100;
  localparam logic [3:0] OP_ANDWF  = 4'b0101;
  localparam logic [3:0] OP_XORWF  = 4'b0110;
  localparam logic [3:0] OP_ADDWF  = 4'b0111;
  localparam logic [3:0] OP_MOVF   = 4'b1000;
  localparam logic [3:0] OP_COMF   = 4'b1001;
  localparam logic [3:0] OP_INCF   = 4'b1010;
  localparam logic [3:0] OP_DECFSZ = 4'b1011;
  localparam logic [3:0] OP_RRF    = 4'b1100;
  localparam logic [3:0] OP_RLF    = 4'b1101;
  localparam logic [3:0] OP_SWAPF  = 4'b1110;
  localparam logic [3:0] OP_INCFSZ = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  localparam logic [1:0] MUX_THROU = 2'd0;
  localparam logic [1:0] MUX_SHIFT = 2'd1;
  localparam logic [1:0] MUX_LOGIC = 2'd2;
  localparam logic [1:0] MUX_ADDER = 2'd3;

  typedef struct packed {
    logic c;
    logic dc;
    logic z;
  } flag_mask_t;

  localparam int STATUS_C  = 0;
  localparam int STATUS_DC = 1;
  localparam int STATUS_Z  = 2;

endpackage

// File: rtl/alu8_seq_dec.sv
// Combinational instruction decoder: {prefix, op, d} -> ALU controls,
// flag-update mask, write-back target and illegal indication.
// Optional skip opcodes enabled by macro ALU8_SEQ_SKIP_EN.
module alu8_seq_dec
  import alu8_seq_pkg::*;
(
  input  logic [1:0] pre,
  input  logic [3:0] op,
  input  logic       d,
  output logic       clr,
  output logic       swap_n_mov,
  output logic       rlf_n_rrf,
  output logic       sub,
  output logic [1:0] op_mux_l,
  output logic [1:0] op_mux_a,
  output logic [1:0] out_mux,
  output logic       a1_w,
  output flag_mask_t mask,
  output logic       wr_f,
  output logic       wr_w,
`ifdef ALU8_SEQ_SKIP_EN
  output logic       skip_chk,
`endif
  output logic       illegal
);

  logic skip_int;

  // Decode table; illegal instructions have all side effects suppressed
  always_comb begin
    clr        = 1'b0;
    swap_n_mov = 1'b0;
    rlf_n_rrf  = 1'b0;
    sub        = 1'b0;
    op_mux_l   = 2'd0;
    op_mux_a   = 2'd0;
    out_mux    = MUX_THROU;
    a1_w       = 1'b0;
    mask       = '0;
    wr_f       = d;
    wr_w       = ~d;
    skip_int   = 1'b0;
    illegal    = 1'b0;
    case (op)
      OP_MOVWF: begin
        if (d) a1_w = 1'b1;
        else begin
          wr_f = 1'b0;
          wr_w = 1'b0;
        end
      end
      OP_CLRF:  begin clr = 1'b1; mask.z = 1'b1; end
      OP_SUBWF: begin out_mux = MUX_ADDER; op_mux_a = 2'd1; sub = 1'b1; mask = '1; end
      OP_DECF:  begin out_mux = MUX_ADDER; op_mux_a = 2'd3; mask.z = 1'b1; end
      OP_IORWF: begin out_mux = MUX_LOGIC; op_mux_l = 2'd0; mask.z = 1'b1; end
      OP_ANDWF: begin out_mux = MUX_LOGIC; op_mux_l = 2'd1; mask.z = 1'b1; end
      OP_XORWF: begin out_mux = MUX_LOGIC; op_mux_l = 2'd2; mask.z = 1'b1; end
      OP_ADDWF: begin out_mux = MUX_ADDER; op_mux_a = 2'd0; mask = '1; end
      OP_MOVF:  begin mask.z = 1'b1; end
      OP_COMF:  begin out_mux = MUX_LOGIC; op_mux_l = 2'd3; mask.z = 1'b1; end
      OP_INCF:  begin out_mux = MUX_ADDER; op_mux_a = 2'd2; mask.z = 1'b1; end
      OP_RRF:   begin out_mux = MUX_SHIFT; mask.c = 1'b1; end
      OP_RLF:   begin out_mux = MUX_SHIFT; rlf_n_rrf = 1'b1; mask.c = 1'b1; end
      OP_SWAPF: begin swap_n_mov = 1'b1; end
`ifdef ALU8_SEQ_SKIP_EN
      OP_DECFSZ: begin out_mux = MUX_ADDER; op_mux_a = 2'd3; skip_int = 1'b1; end
      OP_INCFSZ: begin out_mux = MUX_ADDER; op_mux_a = 2'd2; skip_int = 1'b1; end
`endif
      default:  illegal = 1'b1;
    endcase
    if (pre != 2'b00) illegal = 1'b1;
    if (illegal) begin
      wr_f     = 1'b0;
      wr_w     = 1'b0;
      mask     = '0;
      skip_int = 1'b0;
    end
  end

`ifdef ALU8_SEQ_SKIP_EN
  assign skip_chk = skip_int;
`else
  logic unused_skip;
  assign unused_skip = skip_int;
`endif

endmodule

// File: rtl/alu8_seq_ctrl.sv
// Four-cycle sequencer (IDLE -> READ -> EXEC -> WB) driving the 8-bit ALU.
// Owns W and the C/DC/Z flags. Macro ALU8_SEQ_SKIP_EN adds DECFSZ/INCFSZ
// and the registered skip output.
module alu8_seq_ctrl
  import alu8_seq_pkg::*;
#(
  parameter int                ADDR_W      = 7,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = 7'h03
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [13:0]       instr,
  output logic              done,
  output logic              illegal,
  output logic [ADDR_W-1:0] f_addr,
  input  logic [7:0]        f_rd_data,
  output logic              f_wr_en,
  output logic [7:0]        f_wr_data,
  output logic              alu_clr,
  output logic              alu_swap_n_mov,
  output logic              alu_rlf_n_rrf,
  output logic              alu_sub,
  output logic [1:0]        alu_op_mux_l,
  output logic [1:0]        alu_op_mux_a,
  output logic [1:0]        alu_out_mux,
  output logic              alu_c_in,
  output logic [7:0]        alu_op_a1,
  output logic [7:0]        alu_op_a,
  output logic [7:0]        alu_op_b,
  input  logic [7:0]        alu_result,
  input  logic              alu_c_new,
  input  logic              alu_dc_new,
  input  logic              alu_z_new,
  output logic [7:0]        w_reg,
  output logic              status_c,
  output logic              status_dc,
  output logic              status_z
`ifdef ALU8_SEQ_SKIP_EN
  ,
  output logic              skip
`endif
);

  state_e      state_q, state_d;
  logic [13:0] instr_q, instr_d;
  logic        clr_q, clr_d, swap_q, swap_d, rlf_q, rlf_d, sub_q, sub_d;
  logic [1:0]  mux_l_q, mux_l_d, mux_a_q, mux_a_d, out_mux_q, out_mux_d;
  logic [7:0]  res_q, res_d, w_q, w_d;
  logic        cn_q, cn_d, dcn_q, dcn_d, zn_q, zn_d;
  logic        c_q, c_d, dc_q, dc_d, z_q, z_d;
  logic        done_q, done_d, ill_q, ill_d, wr_en_q, wr_en_d;

  logic        dec_clr, dec_swap, dec_rlf, dec_sub, dec_a1_w;
  logic        dec_wr_f, dec_wr_w, dec_illegal;
  logic [1:0]  dec_mux_l, dec_mux_a, dec_out_mux;
  flag_mask_t  dec_mask;
`ifdef ALU8_SEQ_SKIP_EN
  logic        dec_skip, skip_q, skip_d;
`endif

  alu8_seq_dec u_dec (
    .pre        (instr_q[13:12]),
    .op         (instr_q[11:8]),
    .d          (instr_q[7]),
    .clr        (dec_clr),
    .swap_n_mov (dec_swap),
    .rlf_n_rrf  (dec_rlf),
    .sub        (dec_sub),
    .op_mux_l   (dec_mux_l),
    .op_mux_a   (dec_mux_a),
    .out_mux    (dec_out_mux),
    .a1_w       (dec_a1_w),
    .mask       (dec_mask),
    .wr_f       (dec_wr_f),
    .wr_w       (dec_wr_w),
`ifdef ALU8_SEQ_SKIP_EN
    .skip_chk   (dec_skip),
`endif
    .illegal    (dec_illegal)
  );

  // Next-state and next-output computation for the sequencer
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    clr_d     = clr_q;
    swap_d    = swap_q;
    rlf_d     = rlf_q;
    sub_d     = sub_q;
    mux_l_d   = mux_l_q;
    mux_a_d   = mux_a_q;
    out_mux_d = out_mux_q;
    res_d     = res_q;
    cn_d      = cn_q;
    dcn_d     = dcn_q;
    zn_d      = zn_q;
    w_d       = w_q;
    c_d       = c_q;
    dc_d      = dc_q;
    z_d       = z_q;
    done_d    = done_q;
    ill_d     = ill_q;
    wr_en_d   = wr_en_q;
`ifdef ALU8_SEQ_SKIP_EN
    skip_d    = skip_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        // Controls become valid for the whole EXEC cycle
        clr_d     = dec_clr;
        swap_d    = dec_swap;
        rlf_d     = dec_rlf;
        sub_d     = dec_sub;
        mux_l_d   = dec_mux_l;
        mux_a_d   = dec_mux_a;
        out_mux_d = dec_out_mux;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        res_d     = alu_result;
        cn_d      = alu_c_new;
        dcn_d     = alu_dc_new;
        zn_d      = alu_z_new;
        clr_d     = 1'b0;
        swap_d    = 1'b0;
        rlf_d     = 1'b0;
        sub_d     = 1'b0;
        mux_l_d   = 2'd0;
        mux_a_d   = 2'd0;
        out_mux_d = MUX_THROU;
        done_d    = 1'b1;
        ill_d     = dec_illegal;
        wr_en_d   = dec_wr_f;
`ifdef ALU8_SEQ_SKIP_EN
        skip_d    = dec_skip & (alu_result == 8'h00);
`endif
        state_d   = ST_WB;
      end
      ST_WB: begin
        done_d  = 1'b0;
        ill_d   = 1'b0;
        wr_en_d = 1'b0;
`ifdef ALU8_SEQ_SKIP_EN
        skip_d  = 1'b0;
`endif
        if (dec_wr_w) w_d = res_q;
        // A STATUS write loads all flag bits; affected flags then win
        if (dec_wr_f && (f_addr == STATUS_ADDR)) begin
          c_d  = res_q[STATUS_C];
          dc_d = res_q[STATUS_DC];
          z_d  = res_q[STATUS_Z];
        end
        if (dec_mask.c)  c_d  = cn_q;
        if (dec_mask.dc) dc_d = dcn_q;
        if (dec_mask.z)  z_d  = zn_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      clr_q     <= 1'b0;
      swap_q    <= 1'b0;
      rlf_q     <= 1'b0;
      sub_q     <= 1'b0;
      mux_l_q   <= 2'd0;
      mux_a_q   <= 2'd0;
      out_mux_q <= MUX_THROU;
      res_q     <= 8'h00;
      cn_q      <= 1'b0;
      dcn_q     <= 1'b0;
      zn_q      <= 1'b0;
      w_q       <= 8'h00;
      c_q       <= 1'b0;
      dc_q      <= 1'b0;
      z_q       <= 1'b0;
      done_q    <= 1'b0;
      ill_q     <= 1'b0;
      wr_en_q   <= 1'b0;
`ifdef ALU8_SEQ_SKIP_EN
      skip_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      clr_q     <= clr_d;
      swap_q    <= swap_d;
      rlf_q     <= rlf_d;
      sub_q     <= sub_d;
      mux_l_q   <= mux_l_d;
      mux_a_q   <= mux_a_d;
      out_mux_q <= out_mux_d;
      res_q     <= res_d;
      cn_q      <= cn_d;
      dcn_q     <= dcn_d;
      zn_q      <= zn_d;
      w_q       <= w_d;
      c_q       <= c_d;
      dc_q      <= dc_d;
      z_q       <= z_d;
      done_q    <= done_d;
      ill_q     <= ill_d;
      wr_en_q   <= wr_en_d;
`ifdef ALU8_SEQ_SKIP_EN
      skip_q    <= skip_d;
`endif
    end
  end

  assign instr_ready    = (state_q == ST_IDLE);
  assign f_addr         = instr_q[ADDR_W-1:0];
  assign f_wr_en        = wr_en_q;
  assign f_wr_data      = res_q;
  assign done           = done_q;
  assign illegal        = ill_q;
  assign alu_clr        = clr_q;
  assign alu_swap_n_mov = swap_q;
  assign alu_rlf_n_rrf  = rlf_q;
  assign alu_sub        = sub_q;
  assign alu_op_mux_l   = mux_l_q;
  assign alu_op_mux_a   = mux_a_q;
  assign alu_out_mux    = out_mux_q;
  assign alu_c_in       = c_q;
  assign alu_op_a       = f_rd_data;
  assign alu_op_a1      = dec_a1_w ? w_q : f_rd_data;
  assign alu_op_b       = w_q;
  assign w_reg          = w_q;
  assign status_c       = c_q;
  assign status_dc      = dc_q;
  assign status_z       = z_q;
`ifdef ALU8_SEQ_SKIP_EN
  assign skip           = skip_q;
`endif

endmodule

// File: tb/tb_alu8_seq_ctrl.sv
// Directed testbench for alu8_seq_ctrl with a small behavioural ALU and a
// file register that always returns f_val.
module tb_alu8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [13:0] instr;
  logic        done, illegal;
  logic [6:0]  f_addr;
  logic [7:0]  f_rd_data;
  logic        f_wr_en;
  logic [7:0]  f_wr_data;
  logic        alu_clr, alu_swap_n_mov, alu_rlf_n_rrf, alu_sub;
  logic [1:0]  alu_op_mux_l, alu_op_mux_a, alu_out_mux;
  logic        alu_c_in;
  logic [7:0]  alu_op_a1, alu_op_a, alu_op_b;
  logic [7:0]  alu_result;
  logic        alu_c_new, alu_dc_new, alu_z_new;
  logic [7:0]  w_reg;
  logic        status_c, status_dc, status_z;
`ifdef ALU8_SEQ_SKIP_EN
  logic        skip;
`endif

  logic [7:0]  f_val;
  logic [8:0]  s9;
  logic [4:0]  h5;
  int          n_chk = 0;
  int          n_pass = 0;
  int          lat;
  logic        ob_wr_en, ob_done, ob_ill, ob_skip;
  logic [7:0]  ob_wr_data;
  logic [6:0]  ob_faddr;
  logic [1:0]  ob_mux;

  alu8_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .done(done), .illegal(illegal), .f_addr(f_addr),
    .f_rd_data(f_rd_data), .f_wr_en(f_wr_en), .f_wr_data(f_wr_data),
    .alu_clr(alu_clr), .alu_swap_n_mov(alu_swap_n_mov), .alu_rlf_n_rrf(alu_rlf_n_rrf),
    .alu_sub(alu_sub), .alu_op_mux_l(alu_op_mux_l), .alu_op_mux_a(alu_op_mux_a),
    .alu_out_mux(alu_out_mux), .alu_c_in(alu_c_in), .alu_op_a1(alu_op_a1),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_result(alu_result),
    .alu_c_new(alu_c_new), .alu_dc_new(alu_dc_new), .alu_z_new(alu_z_new),
    .w_reg(w_reg), .status_c(status_c), .status_dc(status_dc), .status_z(status_z)
`ifdef ALU8_SEQ_SKIP_EN
    , .skip(skip)
`endif
  );

  always #5 clk = ~clk;
  assign f_rd_data = f_val;

  // Behavioural ALU responding to the sequencer's control lines
  always_comb begin
    s9 = 9'd0;
    h5 = 5'd0;
    alu_result = 8'h00;
    alu_c_new  = 1'b0;
    alu_dc_new = 1'b0;
    if (!alu_clr) begin
      case (alu_out_mux)
        2'd0: alu_result = alu_swap_n_mov ? {alu_op_a[3:0], alu_op_a[7:4]} : alu_op_a1;
        2'd1: begin
          if (alu_rlf_n_rrf) begin alu_result = {alu_op_a[6:0], alu_c_in}; alu_c_new = alu_op_a[7]; end
          else begin alu_result = {alu_c_in, alu_op_a[7:1]}; alu_c_new = alu_op_a[0]; end
        end
        2'd2: begin
          case (alu_op_mux_l)
            2'd0: alu_result = alu_op_a | alu_op_b;
            2'd1: alu_result = alu_op_a & alu_op_b;
            2'd2: alu_result = alu_op_a ^ alu_op_b;
            default: alu_result = ~alu_op_a;
          endcase
        end
        default: begin
          case (alu_op_mux_a)
            2'd0: begin s9 = {1'b0, alu_op_a} + {1'b0, alu_op_b}; h5 = {1'b0, alu_op_a[3:0]} + {1'b0, alu_op_b[3:0]}; end
            2'd1: begin s9 = {1'b0, alu_op_a} + {1'b0, ~alu_op_b} + 9'd1; h5 = {1'b0, alu_op_a[3:0]} + {1'b0, ~alu_op_b[3:0]} + 5'd1; end
            2'd2: begin s9 = {1'b0, alu_op_a} + 9'd1; h5 = {1'b0, alu_op_a[3:0]} + 5'd1; end
            default: begin s9 = {1'b0, alu_op_a} + 9'h0FF; h5 = {1'b0, alu_op_a[3:0]} + 5'h0F; end
          endcase
          alu_result = s9[7:0];
          alu_c_new  = s9[8];
          alu_dc_new = h5[4];
        end
      endcase
    end
    alu_z_new = (alu_result == 8'h00);
  end

  // Presents one instruction, holds valid until done, records WB observations
  task automatic issue(input logic [13:0] ins, input logic [7:0] fv);
    @(negedge clk);
    f_val = fv; instr = ins; instr_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1; ob_faddr = f_addr; ob_mux = 2'd0;
    while (!done && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) ob_mux = alu_out_mux;
    end
    ob_done = done; ob_wr_en = f_wr_en; ob_wr_data = f_wr_data; ob_ill = illegal;
    ob_skip = 1'b0;
`ifdef ALU8_SEQ_SKIP_EN
    ob_skip = skip;
`endif
    instr_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; instr_valid = 1'b0; instr = 14'h0; f_val = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (instr_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", instr_ready); else n_pass++;
    n_chk++; if (w_reg !== 8'h00) $display("FAIL rst_w: got %h want 00", w_reg); else n_pass++;
    n_chk++; if ({status_c, status_dc, status_z} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {status_c, status_dc, status_z}); else n_pass++;
    n_chk++; if ({done, illegal, f_wr_en} !== 3'b000) $display("FAIL rst_strobes: got %b want 000", {done, illegal, f_wr_en}); else n_pass++;
    n_chk++; if ({alu_clr, alu_swap_n_mov, alu_rlf_n_rrf, alu_sub, alu_op_mux_l, alu_op_mux_a, alu_out_mux} !== 10'd0)
      $display("FAIL rst_alu_ctrl: got %b want 0", {alu_clr, alu_swap_n_mov, alu_rlf_n_rrf, alu_sub, alu_op_mux_l, alu_op_mux_a, alu_out_mux}); else n_pass++;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_addwf;
    issue(14'h0810, 8'h0F);  // MOVF d=0: W=0x0F
    n_chk++; if (w_reg !== 8'h0F) $display("FAIL movf_w: got %h want 0f", w_reg); else n_pass++;
    issue(14'h0720, 8'h01);  // ADDWF d=0
    n_chk++; if (lat !== 3) $display("FAIL addwf_latency: got %0d want 3", lat); else n_pass++;
    n_chk++; if (ob_faddr !== 7'h20) $display("FAIL addwf_faddr: got %h want 20", ob_faddr); else n_pass++;
    n_chk++; if (ob_mux !== 2'd3) $display("FAIL addwf_outmux: got %0d want 3", ob_mux); else n_pass++;
    n_chk++; if (ob_wr_en !== 1'b0) $display("FAIL addwf_wren: got %b want 0", ob_wr_en); else n_pass++;
    n_chk++; if (w_reg !== 8'h10) $display("FAIL addwf_w: got %h want 10", w_reg); else n_pass++;
    n_chk++; if ({status_c, status_dc, status_z} !== 3'b010) $display("FAIL addwf_flags: got %b want 010", {status_c, status_dc, status_z}); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL done_one_shot: got %b want 0", done); else n_pass++;
  endtask

  task automatic test_subwf;
    issue(14'h0810, 8'h05);  // W=0x05
    issue(14'h02A1, 8'h05);  // SUBWF d=1
    n_chk++; if ({ob_wr_en, ob_wr_data} !== {1'b1, 8'h00}) $display("FAIL subwf_wr: got %b/%h want 1/00", ob_wr_en, ob_wr_data); else n_pass++;
    n_chk++; if ({status_c, status_dc, status_z} !== 3'b111) $display("FAIL subwf_flags: got %b want 111", {status_c, status_dc, status_z}); else n_pass++;
    n_chk++; if (w_reg !== 8'h05) $display("FAIL subwf_w: got %h want 05", w_reg); else n_pass++;
  endtask

  task automatic test_rlf;
    issue(14'h0810, 8'h05);  // W=0x05, Z=0
    issue(14'h0083, 8'h00);  // MOVWF STATUS: C=1 DC=0 Z=1
    n_chk++; if ({ob_wr_en, ob_wr_data} !== {1'b1, 8'h05}) $display("FAIL movwf_wr: got %b/%h want 1/05", ob_wr_en, ob_wr_data); else n_pass++;
    n_chk++; if ({status_c, status_dc, status_z} !== 3'b101) $display("FAIL status_write: got %b want 101", {status_c, status_dc, status_z}); else n_pass++;
    issue(14'h0DA2, 8'h80);  // RLF d=1
    n_chk++; if (ob_mux !== 2'd1) $display("FAIL rlf_outmux: got %0d want 1", ob_mux); else n_pass++;
    n_chk++; if ({ob_wr_en, ob_wr_data} !== {1'b1, 8'h01}) $display("FAIL rlf_wr: got %b/%h want 1/01", ob_wr_en, ob_wr_data); else n_pass++;
    n_chk++; if ({status_c, status_dc, status_z} !== 3'b101) $display("FAIL rlf_flags: got %b want 101", {status_c, status_dc, status_z}); else n_pass++;
  endtask

  task automatic test_swapf;
    issue(14'h0E23, 8'hA5);  // SWAPF d=0
    n_chk++; if (w_reg !== 8'h5A) $display("FAIL swapf_w: got %h want 5a", w_reg); else n_pass++;
    n_chk++; if ({status_c, status_dc, status_z} !== 3'b101) $display("FAIL swapf_flags: got %b want 101", {status_c, status_dc, status_z}); else n_pass++;
    issue(14'h0183, 8'h77);  // CLRF STATUS
    n_chk++; if ({ob_wr_en, ob_wr_data} !== {1'b1, 8'h00}) $display("FAIL clrf_wr: got %b/%h want 1/00", ob_wr_en, ob_wr_data); else n_pass++;
    n_chk++; if ({status_c, status_dc, status_z} !== 3'b001) $display("FAIL clrf_status: got %b want 001", {status_c, status_dc, status_z}); else n_pass++;
  endtask

  task automatic test_illegal;
    issue(14'h3FFF, 8'h33);
    n_chk++; if (lat !== 3) $display("FAIL illegal_latency: got %0d want 3", lat); else n_pass++;
    n_chk++; if ({ob_done, ob_ill, ob_wr_en} !== 3'b110) $display("FAIL illegal_strobes: got %b want 110", {ob_done, ob_ill, ob_wr_en}); else n_pass++;
    n_chk++; if (w_reg !== 8'h5A) $display("FAIL illegal_w: got %h want 5a", w_reg); else n_pass++;
    n_chk++; if ({status_c, status_dc, status_z} !== 3'b001) $display("FAIL illegal_flags: got %b want 001", {status_c, status_dc, status_z}); else n_pass++;
    n_chk++; if (illegal !== 1'b0) $display("FAIL illegal_one_shot: got %b want 0", illegal); else n_pass++;
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    f_val = 8'h01; instr = 14'h0720; instr_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;  // EXEC
    n_chk++; if (alu_out_mux !== 2'd3) $display("FAIL abort_exec_mux: got %0d want 3", alu_out_mux); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({f_wr_en, done} !== 2'b00) $display("FAIL abort_strobes: got %b want 00", {f_wr_en, done}); else n_pass++;
    n_chk++; if (w_reg !== 8'h00) $display("FAIL abort_w: got %h want 00", w_reg); else n_pass++;
    n_chk++; if ({status_c, status_dc, status_z} !== 3'b000) $display("FAIL abort_flags: got %b want 000", {status_c, status_dc, status_z}); else n_pass++;
    n_chk++; if (instr_ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", instr_ready); else n_pass++;
    instr_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    issue(14'h0810, 8'h07);  // W=0x07, Z=0
    n_chk++; if (lat !== 3) $display("FAIL post_abort_latency: got %0d want 3", lat); else n_pass++;
    n_chk++; if ({w_reg, status_z} !== {8'h07, 1'b0}) $display("FAIL post_abort_w: got %h/%b want 07/0", w_reg, status_z); else n_pass++;
  endtask

  task automatic test_skip;
`ifdef ALU8_SEQ_SKIP_EN
    issue(14'h0BA4, 8'h01);  // DECFSZ d=1
    n_chk++; if ({ob_wr_en, ob_wr_data} !== {1'b1, 8'h00}) $display("FAIL decfsz_wr: got %b/%h want 1/00", ob_wr_en, ob_wr_data); else n_pass++;
    n_chk++; if (ob_skip !== 1'b1) $display("FAIL decfsz_skip: got %b want 1", ob_skip); else n_pass++;
    n_chk++; if (status_z !== 1'b0) $display("FAIL decfsz_z: got %b want 0", status_z); else n_pass++;
    issue(14'h0FA5, 8'h05);  // INCFSZ d=1
    n_chk++; if ({ob_wr_data, ob_skip, ob_ill} !== {8'h06, 1'b0, 1'b0}) $display("FAIL incfsz: got %h/%b/%b want 06/0/0", ob_wr_data, ob_skip, ob_ill); else n_pass++;
`else
    issue(14'h0BA4, 8'h01);
    n_chk++; if ({ob_ill, ob_wr_en} !== 2'b10) $display("FAIL decfsz_illegal: got %b want 10", {ob_ill, ob_wr_en}); else n_pass++;
    issue(14'h0FA5, 8'h05);
    n_chk++; if ({ob_ill, ob_wr_en} !== 2'b10) $display("FAIL incfsz_illegal: got %b want 10", {ob_ill, ob_wr_en}); else n_pass++;
    n_chk++; if ({w_reg, status_z} !== {8'h07, 1'b0}) $display("FAIL skip_opc_state: got %h/%b want 07/0", w_reg, status_z); else n_pass++;
`endif
  endtask

  initial begin
    test_reset;
    test_addwf;
    test_subwf;
    test_rlf;
    test_swapf;
    test_illegal;
    test_reset_abort;
    test_skip;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
